// File: rtl/cordic_vector_iter.sv
// Iterative full-circle CORDIC vectoring: signed (X,Y) -> binary angle, gain-corrected magnitude, whole degrees.
// One shared micro-rotation stage; result RNUM+1 cycles after accept, held in DONE until out_ready.
module cordic_vector_iter #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 16,
  parameter int RNUM  = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DSIZE-1:0] X,
  input  logic signed [DSIZE-1:0] Y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ASIZE-1:0]        angle,
  output logic [DSIZE:0]          magnitude,
  output logic [8:0]              angle_deg,
  output logic                    busy
);
  localparam int XW = DSIZE + 2;
  localparam int PW = XW + 16;
  localparam int IW = $clog2(RNUM);
  localparam logic signed [PW-1:0] KINV   = PW'(19898);
  localparam logic signed [PW-1:0] MAGMAX = {{(PW-DSIZE-1){1'b0}}, {(DSIZE+1){1'b1}}};
  localparam logic [ASIZE-1:0]     QTR    = {2'b01, {(ASIZE-2){1'b0}}};
  localparam logic [ASIZE-1:0]     THREEQ = {2'b11, {(ASIZE-2){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, COMP, DONE} state_t;

  function automatic logic [ASIZE-1:0] atan_lsb(input int i);
    real r;
    r = $atan(1.0 / (2.0 ** i)) * (2.0 ** ASIZE) / (2.0 * 3.14159265358979323846);
    return ASIZE'($rtoi(r + 0.5));
  endfunction

  logic [ASIZE-1:0] atan_tab [RNUM];
  for (genvar g = 0; g < RNUM; g++) begin : g_tab
    localparam logic [ASIZE-1:0] TV = atan_lsb(g);
    assign atan_tab[g] = TV;
  end

  state_t               state_q;
  logic [IW-1:0]        i_q;
  logic signed [XW-1:0] x_q, y_q;
  logic [ASIZE-1:0]     a_q;
  logic                 zero_q;
  logic                 in_ready_q, busy_q, out_valid_q;
  logic [ASIZE-1:0]     angle_q;
  logic [DSIZE:0]       mag_q;
  logic [8:0]           deg_q;

  logic signed [XW-1:0] xs, ys, x0, y0, x_d, y_d;
  logic [ASIZE-1:0]     a0, a_d, a_fin;
  logic signed [PW-1:0] prod, mag_sh;
  logic [DSIZE:0]       mag_d;
  logic [8:0]           deg_d;

  // Quadrant fold: widen before negating so the most negative input stays exact.
  always_comb begin
    xs = {{2{X[DSIZE-1]}}, X};
    ys = {{2{Y[DSIZE-1]}}, Y};
    x0 = xs;
    y0 = ys;
    a0 = '0;
    if (X[DSIZE-1]) begin
      if (!Y[DSIZE-1]) begin
        x0 = ys;
        y0 = -xs;
        a0 = QTR;
      end else begin
        x0 = -ys;
        y0 = xs;
        a0 = THREEQ;
      end
    end
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    a_d = a_q;
    if (!y_q[XW-1]) begin
      x_d = x_q + (y_q >>> i_q);
      y_d = y_q - (x_q >>> i_q);
      a_d = a_q + atan_tab[i_q];
    end else begin
      x_d = x_q - (y_q >>> i_q);
      y_d = y_q + (x_q >>> i_q);
      a_d = a_q - atan_tab[i_q];
    end
  end

  // A zero vector would otherwise accumulate the sum of the whole table; report angle 0 instead.
  always_comb begin
    a_fin  = zero_q ? '0 : a_q;
    prod   = $signed({{16{x_q[XW-1]}}, x_q}) * KINV;
    mag_sh = prod >>> 15;
    mag_d  = mag_sh[DSIZE:0];
    if (mag_sh[PW-1])
      mag_d = '0;
    else if (mag_sh > MAGMAX)
      mag_d = '1;
    deg_d  = 9'(({9'd0, a_fin} * (ASIZE+9)'(360)) >> ASIZE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      i_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      a_q         <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      angle_q     <= '0;
      mag_q       <= '0;
      deg_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          x_q        <= x0;
          y_q        <= y0;
          a_q        <= a0;
          zero_q     <= (X == '0) && (Y == '0);
          i_q        <= '0;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= ITER;
        end
        ITER: begin
          x_q <= x_d;
          y_q <= y_d;
          a_q <= a_d;
          if (i_q == IW'(RNUM-1)) begin
            i_q     <= '0;
            state_q <= COMP;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        COMP: begin
          angle_q     <= a_fin;
          mag_q       <= mag_d;
          deg_q       <= deg_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign angle     = angle_q;
  assign magnitude = mag_q;
  assign angle_deg = deg_q;
endmodule

// File: tb/tb_cordic_vector_iter.sv
// Bench for cordic_vector_iter: directed vector table, hand sequences for hold/reset, random vs atan2/sqrt model.
module tb_cordic_vector_iter;
  localparam int  DSIZE = 16;
  localparam int  ASIZE = 16;
  localparam int  RNUM  = 12;
  localparam int  LAT   = RNUM + 1;
  localparam real PI    = 3.14159265358979323846;

  logic clock = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic signed [DSIZE-1:0] X, Y;
  logic [ASIZE-1:0] angle;
  logic [DSIZE:0]   magnitude;
  logic [8:0]       angle_deg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  cordic_vector_iter #(.DSIZE(DSIZE), .ASIZE(ASIZE), .RNUM(RNUM)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .out_valid(out_valid), .out_ready(out_ready),
    .angle(angle), .magnitude(magnitude), .angle_deg(angle_deg), .busy(busy)
  );

  typedef struct {
    int x; int y;
    int ang; int atol;
    int mag; int mtol;
    int dlo; int dhi;
  } vec_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic int circ_diff(input int a, input int b);
    int d;
    d = (a - b) % 65536;
    if (d < 0) d += 65536;
    if (d >= 32768) d -= 65536;
    return d;
  endfunction

  function automatic real ideal_ang_real(input int xi, input int yi);
    real t;
    t = $atan2(real'(yi), real'(xi));
    if (t < 0.0) t += 2.0 * PI;
    return t * 65536.0 / (2.0 * PI);
  endfunction

  function automatic real ideal_mag(input int xi, input int yi);
    return $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi));
  endfunction

  task automatic send(input int xi, input int yi);
    int w = 0;
    while (!in_ready && w < 64) begin
      tick();
      w++;
    end
    check("in_ready_before_send", in_ready == 1'b1, in_ready, 1);
    X = DSIZE'(xi);
    Y = DSIZE'(yi);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("accepted_in_ready_low", in_ready == 1'b0, in_ready, 0);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("handshake_out_valid_low", out_valid == 1'b0, out_valid, 0);
    check("handshake_in_ready_high", in_ready == 1'b1, in_ready, 1);
  endtask

  // Checks outputs against the floating-point ideal; tolerance grows for short vectors.
  task automatic check_model(input string tag, input int xi, input int yi, input int mtol);
    real ia, im, dr;
    int  ea, atol, ed, dd;
    ia   = ideal_ang_real(xi, yi);
    im   = ideal_mag(xi, yi);
    ea   = int'(ia) % 65536;
    atol = 12 + int'(real'(RNUM) * 65536.0 / (2.0 * PI * im));
    check({tag, "_angle"}, (circ_diff(int'(angle), ea) <= atol) && (circ_diff(int'(angle), ea) >= -atol),
          angle, ea);
    check({tag, "_mag"}, ((real'(magnitude) - im) <= real'(mtol)) && ((im - real'(magnitude)) <= real'(mtol)),
          magnitude, int'(im));
    dr = $floor(ia * 360.0 / 65536.0);
    ed = int'(dr) % 360;
    dd = (int'(angle_deg) - ed + 360) % 360;
    check({tag, "_deg"}, (dd == 0) || (dd == 1) || (dd == 359), angle_deg, ed);
  endtask

  vec_t vtab[$];

  initial begin
    int lat, ok, seen;
    logic [ASIZE-1:0] cap_ang;
    logic [DSIZE:0]   cap_mag;
    logic [8:0]       cap_deg;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; X = '0; Y = '0;
    tick(); tick();
    check("rst_in_ready", in_ready == 1'b1, in_ready, 1);
    check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
    check("rst_busy", busy == 1'b0, busy, 0);
    check("rst_outputs_zero", (angle == '0) && (magnitude == '0) && (angle_deg == '0),
          angle + magnitude + angle_deg, 0);
    reset = 1'b0;
    tick();

    vtab.push_back('{1000, 0, 0, 8, 1000, 3, 0, 0});
    vtab.push_back('{0, 1000, 16384, 8, 1000, 3, 89, 90});
    vtab.push_back('{-1000, -1000, 40960, 8, 1414, 3, 224, 225});
    vtab.push_back('{0, -1000, 49152, 8, 1000, 3, 269, 270});
    vtab.push_back('{-32768, 0, 32768, 8, 32768, 3, 179, 180});
    vtab.push_back('{-32768, -32768, 40960, 8, 46341, 3, 224, 225});
    vtab.push_back('{1000, -1, 65528, 8, 1000, 3, 359, 0});
    vtab.push_back('{0, 0, 0, 0, 0, 0, 0, 0});

    foreach (vtab[k]) begin
      send(vtab[k].x, vtab[k].y);
      check("busy_after_accept", busy == 1'b1, busy, 1);
      wait_out(lat);
      check("table_latency", lat == LAT, lat, LAT);
      ok = (circ_diff(int'(angle), vtab[k].ang) <= vtab[k].atol) &&
           (circ_diff(int'(angle), vtab[k].ang) >= -vtab[k].atol);
      check($sformatf("table%0d_angle", k), ok != 0, angle, vtab[k].ang);
      check($sformatf("table%0d_mag", k),
            ((int'(magnitude) - vtab[k].mag) <= vtab[k].mtol) &&
            ((vtab[k].mag - int'(magnitude)) <= vtab[k].mtol),
            magnitude, vtab[k].mag);
      if (vtab[k].dlo <= vtab[k].dhi)
        ok = (angle_deg >= 9'(vtab[k].dlo)) && (angle_deg <= 9'(vtab[k].dhi));
      else
        ok = (angle_deg >= 9'(vtab[k].dlo)) || (angle_deg <= 9'(vtab[k].dhi));
      check($sformatf("table%0d_deg", k), ok != 0, angle_deg, vtab[k].dlo);
      release_out();
    end

    // Result held under backpressure while a new sample is offered throughout.
    send(3000, 4000);
    wait_out(lat);
    check("hold_latency", lat == LAT, lat, LAT);
    check_model("hold_first", 3000, 4000, 3);
    cap_ang = angle; cap_mag = magnitude; cap_deg = angle_deg;
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      X = DSIZE'($urandom); Y = DSIZE'($urandom);
      tick();
      check("hold_out_valid", out_valid == 1'b1, out_valid, 1);
      check("hold_in_ready", in_ready == 1'b0, in_ready, 0);
      check("hold_stable", (angle == cap_ang) && (magnitude == cap_mag) && (angle_deg == cap_deg),
            angle, cap_ang);
    end
    X = -16'sd2000; Y = 16'sd1500;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_out_valid_low", out_valid == 1'b0, out_valid, 0);
    check("hs_not_accepted", in_ready == 1'b1, in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("second_accepted", in_ready == 1'b0, in_ready, 0);
    wait_out(lat);
    check("second_latency", lat == LAT, lat, LAT);
    check_model("second", -2000, 1500, 3);
    release_out();

    // Reset during iteration i=5 discards the sample.
    send(5000, -7000);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_in_ready", in_ready == 1'b1, in_ready, 1);
    check("abort_busy", busy == 1'b0, busy, 0);
    check("abort_out_valid", out_valid == 1'b0, out_valid, 0);
    seen = 0;
    repeat (30) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort_no_result", seen == 0, seen, 0);

    // Reset while a result waits in DONE.
    send(-3000, 2500);
    wait_out(lat);
    check("done_rst_latency", lat == LAT, lat, LAT);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("done_rst_out_valid", out_valid == 1'b0, out_valid, 0);
    check("done_rst_outputs_zero", (angle == '0) && (magnitude == '0) && (angle_deg == '0),
          angle + magnitude + angle_deg, 0);

    for (int r = 0; r < 40; r++) begin
      int xi, yi;
      xi = int'($urandom_range(32767, 4096));
      yi = int'($urandom_range(32767, 4096));
      if ($urandom_range(1, 0) == 1) xi = -xi;
      if ($urandom_range(1, 0) == 1) yi = -yi;
      send(xi, yi);
      wait_out(lat);
      check("rand_latency", lat == LAT, lat, LAT);
      repeat ($urandom_range(3, 0)) tick();
      check_model($sformatf("rand%0d", r), xi, yi, 5);
      release_out();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
